// File: rtl/sccb_cfg_pkg.sv
// ============================================================================
// Module      : sccb_cfg_pkg
// Description : Shared opcodes, FSM state encoding and tick helper for the
//               SCCB configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sccb_cfg_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT_LOW  = 4'd4,
    ST_WAIT_HIGH = 4'd5,
    ST_DELAY     = 4'd6,
    ST_DONE      = 4'd7,
    ST_FAIL      = 4'd8
  } state_t;

  function automatic longint TICKS_PER_MS(input longint clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sccb_cfg_delay_timer.sv
// ============================================================================
// Module      : sccb_cfg_delay_timer
// Description : Millisecond delay timer; loads count*ticks-1 and counts down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_cfg_delay_timer
  import sccb_cfg_pkg::*;
#(
  parameter int CLK_FREQ = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] count_ms,
  input  logic        run,
  output logic        expired
);

  localparam longint c_tpm     = TICKS_PER_MS(longint'(CLK_FREQ));
  localparam int     c_timer_w = $clog2(65535 * c_tpm + 1);
  localparam logic [c_timer_w-1:0] c_tpm_w = c_timer_w'(c_tpm);

  logic [c_timer_w-1:0] r_count;
  logic [c_timer_w-1:0] w_load_val;

  // A zero-length delay still occupies one cycle in the DELAY state.
  always_comb begin
    w_load_val = '0;
    if (count_ms != 16'd0)
      w_load_val = c_timer_w'(count_ms) * c_tpm_w - c_timer_w'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (load)
      r_count <= w_load_val;
    else if (run && !expired)
      r_count <= r_count - c_timer_w'(1);
  end

  assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sccb_config_sequencer.sv
// ============================================================================
// Module      : sccb_config_sequencer
// Description : Walks a command ROM and issues register writes to an SCCB
//               master, with ms delays, NACK retry and busy/done/error status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int REG_AW    = 8,
  parameter int REG_DW    = 8,
  parameter int ROM_AW    = 8,
  parameter int ROM_LAT   = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [2+REG_AW+REG_DW-1:0] rom_data,
  input  logic                       sccb_ready,
  input  logic                       sccb_nack,
  output logic                       sccb_start,
  output logic [REG_AW-1:0]          sccb_addr,
  output logic [REG_DW-1:0]          sccb_data,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [ROM_AW-1:0]          cmd_count
);

  localparam int c_rom_w   = 2 + REG_AW + REG_DW;
  localparam int c_retry_w = $clog2(MAX_RETRY + 2);
  localparam logic [ROM_AW-1:0] c_last_addr = '1;
  // A combinational ROM needs no FETCH wait; decode directly on the new address.
  localparam state_t c_fetch_state = (ROM_LAT == 0) ? ST_DECODE : ST_FETCH;

  state_t               r_state, w_state_d;
  logic [ROM_AW-1:0]    r_rom_addr, w_rom_addr_d;
  logic [ROM_AW-1:0]    r_cmd_count, w_cmd_count_d;
  logic [REG_AW-1:0]    r_sccb_addr, w_sccb_addr_d;
  logic [REG_DW-1:0]    r_sccb_data, w_sccb_data_d;
  logic                 r_busy, w_busy_d;
  logic                 r_done, w_done_d;
  logic                 r_error, w_error_d;
  logic [c_retry_w-1:0] r_retry, w_retry_d;
  logic [3:0]           r_wl_cnt, w_wl_cnt_d;

  logic [1:0] w_op;
  logic       w_sccb_start;
  logic       w_timer_load;
  logic       w_timer_run;
  logic       w_timer_expired;
  logic       w_xfer_end;
  logic       w_advance;
  logic       w_fail;

  assign w_op = rom_data[c_rom_w-1 -: 2];

  sccb_cfg_delay_timer #(
    .CLK_FREQ (CLK_FREQ)
  ) u_delay_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_timer_load),
    .count_ms (rom_data[15:0]),
    .run      (w_timer_run),
    .expired  (w_timer_expired)
  );

  always_comb begin
    w_state_d     = r_state;
    w_rom_addr_d  = r_rom_addr;
    w_cmd_count_d = r_cmd_count;
    w_sccb_addr_d = r_sccb_addr;
    w_sccb_data_d = r_sccb_data;
    w_busy_d      = r_busy;
    w_done_d      = r_done;
    w_error_d     = r_error;
    w_retry_d     = r_retry;
    w_wl_cnt_d    = r_wl_cnt;
    w_sccb_start  = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_run   = 1'b0;
    w_xfer_end    = 1'b0;
    w_advance     = 1'b0;
    w_fail        = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          w_rom_addr_d  = '0;
          w_cmd_count_d = '0;
          w_done_d      = 1'b0;
          w_error_d     = 1'b0;
          w_busy_d      = 1'b1;
          w_retry_d     = '0;
          w_state_d     = c_fetch_state;
        end
      end
      ST_FETCH: w_state_d = ST_DECODE;
      ST_DECODE: begin
        case (w_op)
          OP_WRITE: begin
            w_sccb_addr_d = rom_data[REG_DW +: REG_AW];
            w_sccb_data_d = rom_data[REG_DW-1:0];
            w_state_d     = ST_ISSUE;
          end
          OP_DELAY: begin
            w_timer_load = 1'b1;
            w_state_d    = ST_DELAY;
          end
          OP_END: begin
            w_done_d  = 1'b1;
            w_busy_d  = 1'b0;
            w_state_d = ST_DONE;
          end
          default: w_fail = 1'b1;
        endcase
      end
      ST_ISSUE: begin
        if (sccb_ready) begin
          w_sccb_start = 1'b1;
          w_wl_cnt_d   = 4'd0;
          w_state_d    = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        // A master that never drops ready is taken to have completed the write.
        if (!sccb_ready)
          w_state_d = ST_WAIT_HIGH;
        else if (r_wl_cnt == 4'd15)
          w_xfer_end = 1'b1;
        else
          w_wl_cnt_d = r_wl_cnt + 4'd1;
      end
      ST_WAIT_HIGH: w_xfer_end = sccb_ready;
      ST_DELAY: begin
        w_timer_run = 1'b1;
        w_advance   = w_timer_expired;
      end
      default: w_state_d = ST_IDLE;
    endcase

    if (w_xfer_end) begin
      if (!sccb_nack) begin
        w_cmd_count_d = r_cmd_count + ROM_AW'(1);
        w_retry_d     = '0;
        w_advance     = 1'b1;
      end else if (r_retry < c_retry_w'(MAX_RETRY)) begin
        w_retry_d = r_retry + c_retry_w'(1);
        w_state_d = ST_ISSUE;
      end else begin
        w_fail = 1'b1;
      end
    end

    if (w_advance) begin
      if (r_rom_addr == c_last_addr) begin
        w_fail = 1'b1;
      end else begin
        w_rom_addr_d = r_rom_addr + ROM_AW'(1);
        w_state_d    = c_fetch_state;
      end
    end

    if (w_fail) begin
      w_state_d = ST_FAIL;
      w_error_d = 1'b1;
      w_busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rom_addr  <= '0;
      r_cmd_count <= '0;
      r_sccb_addr <= '0;
      r_sccb_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_retry     <= '0;
      r_wl_cnt    <= 4'd0;
    end else begin
      r_state     <= w_state_d;
      r_rom_addr  <= w_rom_addr_d;
      r_cmd_count <= w_cmd_count_d;
      r_sccb_addr <= w_sccb_addr_d;
      r_sccb_data <= w_sccb_data_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_error     <= w_error_d;
      r_retry     <= w_retry_d;
      r_wl_cnt    <= w_wl_cnt_d;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign cmd_count  = r_cmd_count;
  assign sccb_addr  = r_sccb_addr;
  assign sccb_data  = r_sccb_data;
  assign sccb_start = w_sccb_start;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_sccb_config_sequencer.sv
// ============================================================================
// Module      : tb_sccb_config_sequencer
// Description : Scoreboard bench with a ROM model and an SCCB master model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sccb_config_sequencer;
  import sccb_cfg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [7:0]  rom_addr;
  logic [17:0] rom_data;
  logic        sccb_ready = 1'b1;
  logic        sccb_nack  = 1'b0;
  logic        sccb_start;
  logic [7:0]  sccb_addr, sccb_data, cmd_count;
  logic        busy, done, error;

  logic        start16;
  logic [3:0]  rom16_addr;
  logic [25:0] rom16_data;
  logic        ready16 = 1'b1;
  logic        nack16  = 1'b0;
  logic        s16_start;
  logic [15:0] s16_addr;
  logic [7:0]  s16_data;
  logic [3:0]  cmd16;
  logic        busy16, done16, error16;

  sccb_config_sequencer #(
    .CLK_FREQ(1000000), .REG_AW(8), .REG_DW(8), .ROM_AW(8), .ROM_LAT(1), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_ready(sccb_ready), .sccb_nack(sccb_nack), .sccb_start(sccb_start),
    .sccb_addr(sccb_addr), .sccb_data(sccb_data), .busy(busy), .done(done),
    .error(error), .cmd_count(cmd_count)
  );

  sccb_config_sequencer #(
    .CLK_FREQ(1000000), .REG_AW(16), .REG_DW(8), .ROM_AW(4), .ROM_LAT(0), .MAX_RETRY(3)
  ) dut16 (
    .clk(clk), .reset(reset), .start(start16), .rom_addr(rom16_addr), .rom_data(rom16_data),
    .sccb_ready(ready16), .sccb_nack(nack16), .sccb_start(s16_start),
    .sccb_addr(s16_addr), .sccb_data(s16_data), .busy(busy16), .done(done16),
    .error(error16), .cmd_count(cmd16)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: registered (latency 1) for dut, combinational for dut16
  logic [17:0] rom_mem [256];
  logic [25:0] rom16_mem [16];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];
  assign rom16_data = rom16_mem[rom16_addr];

  // SCCB master model: drops ready for low_cycles after each request
  int  low_cycles = 3;
  int  m_cnt = 0;
  logic m_nack = 1'b0;
  bit  nack_q[$];
  always @(posedge clk) begin
    if (reset) begin
      sccb_ready <= 1'b1;
      sccb_nack  <= 1'b0;
      m_cnt      <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        sccb_ready <= 1'b1;
        sccb_nack  <= m_nack;
      end
    end else begin
      sccb_nack <= 1'b0;
      if (sccb_start && low_cycles > 0) begin
        sccb_ready <= 1'b0;
        m_cnt      <= low_cycles;
        if (nack_q.size() > 0) m_nack <= nack_q.pop_front();
        else m_nack <= 1'b0;
      end
    end
  end

  int c16 = 0;
  always @(posedge clk) begin
    if (reset) begin
      ready16 <= 1'b1;
      c16     <= 0;
    end else if (c16 > 0) begin
      c16 <= c16 - 1;
      if (c16 == 1) ready16 <= 1'b1;
    end else if (s16_start) begin
      ready16 <= 1'b0;
      c16     <= 2;
    end
  end

  // Scoreboard monitors
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int pulses = 0;
  int last_pulse_cyc = 0;
  always @(negedge clk) begin
    if (sccb_start) begin
      pulses++;
      last_pulse_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", sccb_addr, sccb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({sccb_addr, sccb_data} !== mon_e) begin
          errors++;
          $display("FAIL write_payload: got %h/%h, required %h/%h", sccb_addr, sccb_data, mon_e[15:8], mon_e[7:0]);
        end
      end
    end
  end

  logic [23:0] exp16_q[$];
  logic [23:0] mon16_e;
  int pulses16 = 0;
  always @(negedge clk) begin
    if (s16_start) begin
      pulses16++;
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write16: got addr=%h data=%h, required no write", s16_addr, s16_data);
      end else begin
        mon16_e = exp16_q.pop_front();
        if ({s16_addr, s16_data} !== mon16_e) begin
          errors++;
          $display("FAIL write16_payload: got %h/%h, required %h/%h", s16_addr, s16_data, mon16_e[23:8], mon16_e[7:0]);
        end
      end
    end
  end

  function automatic logic [17:0] cmd(input logic [1:0] op, input logic [15:0] payload);
    return {op, payload};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = cmd(OP_END, 16'h0000);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_timeout: done=%b error=%b after %0d cycles, required done or error", name, done, error, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if ({busy, done, error, sccb_start} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {busy, done, error, sccb_start});
    end
    checks++;
    if ({rom_addr, cmd_count} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_counters: got %h, required 0000", {rom_addr, cmd_count});
    end
    checks++;
    if ({sccb_addr, sccb_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: got %h, required 0000", {sccb_addr, sccb_data});
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_writes();
    int p0;
    clear_rom();
    rom_mem[0] = cmd(OP_WRITE, 16'h1280);
    rom_mem[1] = cmd(OP_WRITE, 16'h1101);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1101);
    p0 = pulses;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    wait_end("basic", 2000);
    checks++;
    if ({done, error, busy} !== 3'b100 || cmd_count !== 8'd2) begin
      errors++;
      $display("FAIL basic_status: got done/err/busy=%b cnt=%0d, required 100 cnt=2", {done, error, busy}, cmd_count);
    end
    checks++;
    if (pulses - p0 !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_pulses: got %0d pulses, %0d pending, required 2 and 0", pulses - p0, exp_q.size());
    end
  endtask

  task automatic test_delay();
    int t0, lat;
    clear_rom();
    rom_mem[0] = cmd(OP_DELAY, 16'd2);
    rom_mem[1] = cmd(OP_WRITE, 16'h3A04);
    exp_q.push_back(16'h3A04);
    t0 = cyc;
    pulse_start();
    wait_end("delay", 5000);
    lat = last_pulse_cyc - t0 - 1;
    // 2 ms at 1 MHz plus the fetch/decode steps around the delay
    checks++;
    if (lat < 2000 || lat > 2006) begin
      errors++;
      $display("FAIL delay_latency: got %0d cycles, required 2000..2006", lat);
    end
    checks++;
    if (done !== 1'b1 || cmd_count !== 8'd1) begin
      errors++;
      $display("FAIL delay_status: got done=%b cnt=%0d, required done=1 cnt=1", done, cmd_count);
    end
  endtask

  task automatic test_retry();
    int p0;
    clear_rom();
    rom_mem[0] = cmd(OP_WRITE, 16'h55AA);
    nack_q = '{1'b1, 1'b1, 1'b0};
    repeat (3) exp_q.push_back(16'h55AA);
    p0 = pulses;
    pulse_start();
    wait_end("retry", 2000);
    checks++;
    if ({done, error} !== 2'b10 || pulses - p0 !== 3 || cmd_count !== 8'd1) begin
      errors++;
      $display("FAIL retry_recover: got done/err=%b pulses=%0d cnt=%0d, required 10 pulses=3 cnt=1",
               {done, error}, pulses - p0, cmd_count);
    end
  endtask

  task automatic test_retry_exhausted();
    int p0;
    clear_rom();
    rom_mem[0] = cmd(OP_WRITE, 16'h6677);
    nack_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    repeat (4) exp_q.push_back(16'h6677);
    p0 = pulses;
    pulse_start();
    wait_end("exhaust", 2000);
    checks++;
    if ({done, error, busy} !== 3'b010 || pulses - p0 !== 4) begin
      errors++;
      $display("FAIL exhaust_status: got done/err/busy=%b pulses=%0d, required 010 pulses=4", {done, error, busy}, pulses - p0);
    end
    checks++;
    if (rom_addr !== 8'd0 || cmd_count !== 8'd0) begin
      errors++;
      $display("FAIL exhaust_counters: got addr=%0d cnt=%0d, required 0 and 0", rom_addr, cmd_count);
    end
    exp_q.push_back(16'h6677);
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rerun_clear: got error=%b busy=%b, required 0 and 1", error, busy);
    end
    wait_end("rerun", 2000);
    checks++;
    if (done !== 1'b1 || cmd_count !== 8'd1) begin
      errors++;
      $display("FAIL rerun_done: got done=%b cnt=%0d, required 1 and 1", done, cmd_count);
    end
  endtask

  task automatic test_zero_drop();
    clear_rom();
    rom_mem[0] = cmd(OP_WRITE, 16'h0102);
    exp_q.push_back(16'h0102);
    low_cycles = 0;
    pulse_start();
    wait_end("zero_drop", 500);
    low_cycles = 3;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cmd_count !== 8'd1) begin
      errors++;
      $display("FAIL zero_drop_status: got done=%b err=%b cnt=%0d, required 1 0 1", done, error, cmd_count);
    end
  endtask

  task automatic test_reserved();
    clear_rom();
    rom_mem[0] = cmd(OP_WRITE, 16'h0111);
    rom_mem[1] = cmd(OP_WRITE, 16'h0222);
    rom_mem[2] = cmd(OP_DELAY, 16'd0);
    rom_mem[3] = cmd(OP_DELAY, 16'd0);
    rom_mem[4] = cmd(OP_DELAY, 16'd0);
    rom_mem[5] = cmd(OP_RSVD, 16'h0000);
    exp_q.push_back(16'h0111);
    exp_q.push_back(16'h0222);
    pulse_start();
    wait_end("reserved", 2000);
    checks++;
    if ({done, error} !== 2'b01 || rom_addr !== 8'd5 || cmd_count !== 8'd2) begin
      errors++;
      $display("FAIL reserved_op: got done/err=%b addr=%0d cnt=%0d, required 01 addr=5 cnt=2",
               {done, error}, rom_addr, cmd_count);
    end
  endtask

  task automatic test_reset_mid_delay();
    int p0;
    clear_rom();
    rom_mem[0] = cmd(OP_WRITE, 16'h2021);
    rom_mem[1] = cmd(OP_DELAY, 16'd5);
    rom_mem[2] = cmd(OP_WRITE, 16'h2223);
    exp_q.push_back(16'h2021);
    pulse_start();
    tick(100);
    checks++;
    if (busy !== 1'b1 || rom_addr !== 8'd1) begin
      errors++;
      $display("FAIL mid_delay_state: got busy=%b addr=%0d, required 1 and 1", busy, rom_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, error, sccb_start} !== 4'b0000 || {rom_addr, cmd_count} !== 16'h0000) begin
      errors++;
      $display("FAIL mid_delay_reset: got flags=%b addr=%0d cnt=%0d, required 0000 0 0",
               {busy, done, error, sccb_start}, rom_addr, cmd_count);
    end
    reset = 1'b0;
    p0 = pulses;
    tick(6000);
    checks++;
    if (pulses !== p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_delay_quiet: got %0d pulses busy=%b, required 0 and 0", pulses - p0, busy);
    end
  endtask

  task automatic test_wide();
    int k = 0;
    for (int i = 0; i < 16; i++) rom16_mem[i] = {OP_END, 24'h000000};
    rom16_mem[0] = {OP_WRITE, 16'h3008, 8'h82};
    exp16_q.push_back(24'h3008_82);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    while (!(done16 || error16) && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done16 !== 1'b1 || error16 !== 1'b0 || cmd16 !== 4'd1 || pulses16 !== 1) begin
      errors++;
      $display("FAIL wide_status: got done=%b err=%b cnt=%0d pulses=%0d, required 1 0 1 1",
               done16, error16, cmd16, pulses16);
    end
    checks++;
    if (s16_addr !== 16'h3008 || s16_data !== 8'h82) begin
      errors++;
      $display("FAIL wide_bus: got %h/%h, required 3008/82", s16_addr, s16_data);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start16 = 1'b0;
    test_reset();
    test_basic_writes();
    test_delay();
    test_retry();
    test_retry_exhausted();
    test_zero_drop();
    test_reserved();
    test_reset_mid_delay();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
